// File: rtl/bam8_err_monitor_if.sv
// Sample bus between a BAM multiplier under test and bam8_err_monitor.
//
// Handshake: a sample (a, b, approx) transfers on a rising clk edge where
// in_valid && in_ready are both high. The payload must be stable whenever
// in_valid is high. in_valid without in_ready is simply dropped: the sink
// keeps no backlog, so the source does not need to hold the sample.
interface bam8_err_monitor_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] approx;

    modport master (output in_valid, a, b, approx, input in_ready);
    modport slave  (input in_valid, a, b, approx, output in_ready);
endinterface

// File: rtl/bam8_err_monitor.sv
// bam8_err_monitor: error-statistics collector placed after an 8x8 unsigned
// broken-array approximate multiplier. For each accepted (a, b, approx) it
// forms e = |a*b - approx| and accumulates sum, max and nonzero count over a
// programmed number of samples.
//
// Optional feature: define BAM_ERR_MSE_EN to add err_sq_sum, a saturating
// sum of e*e that shares the sum_ovf flag. Without the macro the squarer,
// its accumulator and the port are absent.
//
// fsm_state is a debug view of the control FSM (0 IDLE, 1 RUN, 2 DRAIN,
// 3 DONE).
module bam8_err_monitor #(
    parameter int CNT_W = 16,
    parameter int SUM_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [CNT_W-1:0]    sample_cnt,
    bam8_err_monitor_if.slave   smp,
    output logic                busy,
    output logic                done,
    output logic [SUM_W-1:0]    err_sum,
    output logic [15:0]         err_max,
    output logic [CNT_W-1:0]    err_cnt,
    output logic                sum_ovf,
`ifdef BAM_ERR_MSE_EN
    output logic [2*SUM_W-1:0]  err_sq_sum,
`endif
    output logic [1:0]          fsm_state
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int SQ_W = 2 * SUM_W;

    logic [1:0]       state;
    logic [CNT_W-1:0] target;
    logic [CNT_W-1:0] acc_cnt;

    logic             accept;
    logic             start_ok;
    logic             last_accept;

    logic [15:0]      exact;
    logic [15:0]      abs_err;

    logic             s1_valid;
    logic [15:0]      s1_err;

    logic [SUM_W:0]   sum_ext;
    logic             ovf_now;

`ifdef BAM_ERR_MSE_EN
    logic [31:0]      sq;
    logic [SQ_W:0]    sq_ext;
`endif

    // Sink is ready for exactly the RUN state; the FSM leaves RUN on the
    // target-th accept, so in_ready drops the following cycle.
    assign smp.in_ready = (state == ST_RUN);
    assign busy         = (state == ST_RUN) || (state == ST_DRAIN);
    assign done         = (state == ST_DONE);
    assign fsm_state    = state;

    // Handshake decode and run-control qualifiers.
    always_comb begin
        accept      = smp.in_valid && (state == ST_RUN);
        start_ok    = start && ((state == ST_IDLE) || (state == ST_DONE));
        last_accept = accept && (acc_cnt == (target - CNT_W'(1)));
    end

    // Exact product and absolute error; approx above exact is folded, not wrapped.
    always_comb begin
        exact = {8'd0, smp.a} * {8'd0, smp.b};
        if (exact >= smp.approx) begin
            abs_err = exact - smp.approx;
        end else begin
            abs_err = smp.approx - exact;
        end
    end

    // One-bit-wider sums expose the carry that signals saturation.
    always_comb begin
        sum_ext = {1'b0, err_sum} + {{(SUM_W-15){1'b0}}, s1_err};
`ifdef BAM_ERR_MSE_EN
        sq      = {16'd0, s1_err} * {16'd0, s1_err};
        sq_ext  = {1'b0, err_sq_sum} + {{(SQ_W-31){1'b0}}, sq};
        ovf_now = sum_ext[SUM_W] || sq_ext[SQ_W];
`else
        ovf_now = sum_ext[SUM_W];
`endif
    end

    // Control FSM: run setup, sample counting and pipeline drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            target  <= '0;
            acc_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        target  <= sample_cnt;
                        acc_cnt <= '0;
                        state   <= (sample_cnt == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        acc_cnt <= acc_cnt + CNT_W'(1);
                    end
                    if (last_accept) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // S2 has no register of its own beyond the accumulators,
                    // so once S1 is empty every sample has been folded in.
                    if (!s1_valid) begin
                        state <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Stage 1: register the absolute error of each accepted sample.
    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            s1_valid <= 1'b0;
            s1_err   <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_err <= abs_err;
            end
        end
    end

    // Stage 2: fold the stage-1 error into the saturating statistics.
    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            err_sum    <= '0;
            err_max    <= '0;
            err_cnt    <= '0;
            sum_ovf    <= 1'b0;
`ifdef BAM_ERR_MSE_EN
            err_sq_sum <= '0;
`endif
        end else if (s1_valid) begin
            if (sum_ext[SUM_W]) begin
                err_sum <= '1;
            end else begin
                err_sum <= sum_ext[SUM_W-1:0];
            end
`ifdef BAM_ERR_MSE_EN
            if (sq_ext[SQ_W]) begin
                err_sq_sum <= '1;
            end else begin
                err_sq_sum <= sq_ext[SQ_W-1:0];
            end
`endif
            if (s1_err > err_max) begin
                err_max <= s1_err;
            end
            if (s1_err != 16'd0) begin
                err_cnt <= err_cnt + CNT_W'(1);
            end
            sum_ovf <= sum_ovf || ovf_now;
        end
    end

endmodule
